rr_arb4_p: RTL and testbench
============================

# rr_arb4_p

Round-robin arbiter that shares one N-bit output channel among four requesters. It registers the winning select and steers the chosen requester's data through a 4:1 mux. It sits between four producer blocks and a single consumer with a valid/ready handshake, and returns a per-requester acknowledge when each beat is accepted.

## Interface
- N, 4, data width of each requester and of the output channel
- MAX_BURST, 4, maximum consecutive beats for one owner; used only with burst mode
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- req  in  4  request from requester i; held high while its data is pending
- d3, d2, d1, d0  in  N each  requester data; stable while req[i] is high and not acked
- out_ready  in  1  consumer accepts a beat
- out_valid  out  1  output beat valid
- out_data  out  N  data of the granted requester
- out_src  out  2  index of the granted requester
- gnt  out  4  one-hot grant (registered)
- ack  out  4  one-hot, high for one cycle when requester i's beat transfers

## Operation
- States: IDLE (no owner) and BUSY (owner = sel). Registers: state, sel[1:0], ptr[1:0], beat_cnt.
- Arbitration search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req wins.
- IDLE: if req != 0, then sel <= winner, state <= BUSY, ptr <= winner+1. Otherwise stay in IDLE.
- BUSY outputs:
  - gnt = onehot(sel)
  - out_src = sel
  - out_data = d[sel] (combinational through the mux)
  - out_valid = req[sel]
- Transfer occurs when out_valid & out_ready. Then ack[sel] = 1 and re-arbitration happens in the same cycle:
  - If req has any bit set, sel <= winner and ptr <= winner+1; stay in BUSY, with no bubble between beats.
  - If req is all zero, go to IDLE.
- Withdrawal: in BUSY with req[sel]=0 and no transfer, re-arbitrate exactly as above. No ack is issued.
- In IDLE: gnt=0, out_valid=0, ack=0, out_src=sel.
- beat_cnt is 0..MAX_BURST-1 with width $clog2(MAX_BURST). It clears on every owner change.

## Timing
- Reset values (clk edge with rst_n=0): state=IDLE, sel=0, ptr=0, beat_cnt=0, gnt=0, out_valid=0, ack=0, out_src=0. out_data shows d0 during reset and is don't-care while out_valid=0.
- Reset asserted mid-beat aborts the beat with no ack. Arbitration restarts from ptr=0.
- Latency:
  - req rising in IDLE at cycle t gives gnt/out_valid at t+1.
  - A transfer at cycle t with other requests pending gives the new owner valid at t+1.
- ack is combinational in the transfer cycle. Requester i drops or advances its data on the following edge.
- req changes in the same cycle as a transfer use the current-cycle req vector.
- out_valid never asserts without exactly one gnt bit set.
- Starvation bound, non-burst: a continuously requesting requester is served within 4 transfers.

## Configuration
- RR_ARB4_BURST_EN defined: on a transfer, if req[sel] is still 1 and beat_cnt < MAX_BURST-1, the owner keeps the grant, beat_cnt increments, and ptr is unchanged. Otherwise the arbiter rotates normally and beat_cnt clears. Starvation bound becomes 3*MAX_BURST+1 transfers.
- RR_ARB4_BURST_EN undefined: the grant rotates after every transfer. beat_cnt and MAX_BURST are unused, and the register is not synthesised.
- Ports are identical in both builds.

## Structure
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
  - the search-order rotate function (4-bit req, 2-bit ptr → 2-bit winner plus found flag)
- Sub-module: mux4to1_p #(N), instantiated once with sel driving its select. There is no other hierarchy.

## Test plan
- Reset: rst_n=0 for 2 cycles with req=4'b1111 → gnt=0, out_valid=0, ack=0; first grant after release goes to requester 0, one cycle after release.
- Single requester: req=4'b0100, d2=4'hA, out_ready=1 → out_valid at t+1 with out_data=4'hA, out_src=2, ack=4'b0100. The same requester is re-granted back-to-back with no bubble.
- Fairness (non-burst): req=4'b1111 held, out_ready=1 → out_src sequence 0,1,2,3,0,… with one ack per cycle.
- Backpressure: out_ready=0 for 5 cycles with req=4'b0011 → out_valid, gnt=4'b0001 and out_data stable, ack=0. When out_ready=1, ack=4'b0001, then owner 1.
- Withdrawal and mid-operation reset: owner 3 drops req with out_ready=0 → no ack, next owner 0 (req=4'b0001). Then rst_n=0 while BUSY → next cycle IDLE, all outputs at reset values.
- Burst (RR_ARB4_BURST_EN, MAX_BURST=4): req=4'b0011 held, out_ready=1 → out_src 0,0,0,0,1,1,1,1,0…

Source files
------------

// File: rtl/rr_arb4_p_pkg.sv
// rr_arb4_p shared types: FSM state encoding and the
// round-robin search helper used by the arbiter top.
package rr_arb4_p_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First asserted req in order ptr, ptr+1, ptr+2, ptr+3.
  function automatic pick_t rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    pick_t      p;
    logic [1:0] i;
    p = '0;
    for (int k = 3; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (req[i]) begin
        p.found = 1'b1;
        p.idx   = i;
      end
    end
    return p;
  endfunction

  function automatic logic [3:0] onehot4(
    input logic [1:0] s
  );
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_arb4_p_mux.sv
// rr_arb4_p data steering: 4:1 mux selecting the
// granted requester's data onto the output channel.
module mux4to1_p #(
  parameter int N = 4
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [N-1:0] y
);

  // Pure combinational select.
  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb4_p.sv
// rr_arb4_p: 4-way round-robin arbiter with valid/ready output.
// Define RR_ARB4_BURST_EN to let an owner keep up to MAX_BURST beats.
module rr_arb4_p
  import rr_arb4_p_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d0,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_src,
  output logic [3:0]   gnt,
  output logic [3:0]   ack
);

  state_t     state;
  state_t     nxt_state;
  logic [1:0] sel;
  logic [1:0] nxt_sel;
  logic [1:0] ptr;
  logic [1:0] nxt_ptr;
  logic [3:0] nxt_gnt;
  logic       busy;
  logic       xfer;
  logic       rearb;
  pick_t      pick;

`ifdef RR_ARB4_BURST_EN
  localparam int BW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST =
    BW'(MAX_BURST - 1);
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] nxt_cnt;
  logic          keep;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_BURST > 0);
`endif

  assign busy      = (state == ST_BUSY);
  assign out_valid = busy & req[sel];
  assign out_src   = sel;
  assign xfer      = out_valid & out_ready;
  assign ack       = xfer ? onehot4(sel) : 4'b0000;
  assign pick      = rr_pick(req, ptr);

  // A transfer or a withdrawn owner hands the channel on.
  assign rearb = busy & (xfer | ~req[sel]);

`ifdef RR_ARB4_BURST_EN
  assign keep = xfer & req[sel] & (beat_cnt < LAST);
`endif

  mux4to1_p #(.N(N)) u_mux (
    .sel (sel),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .y   (out_data)
  );

  // Next owner, pointer and state from the search result.
  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    nxt_ptr   = ptr;
`ifdef RR_ARB4_BURST_EN
    nxt_cnt   = beat_cnt;
`endif
    if (!busy || rearb) begin
`ifdef RR_ARB4_BURST_EN
      if (keep) begin
        nxt_cnt = beat_cnt + 1'b1;
      end else
`endif
      if (pick.found) begin
        nxt_state = ST_BUSY;
        nxt_sel   = pick.idx;
        nxt_ptr   = pick.idx + 2'd1;
`ifdef RR_ARB4_BURST_EN
        nxt_cnt   = '0;
`endif
      end else begin
        nxt_state = ST_IDLE;
`ifdef RR_ARB4_BURST_EN
        nxt_cnt   = '0;
`endif
      end
    end
    nxt_gnt = (nxt_state == ST_BUSY) ?
              onehot4(nxt_sel) : 4'b0000;
  end

  // Arbiter registers, including the registered grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= nxt_state;
      sel   <= nxt_sel;
      ptr   <= nxt_ptr;
      gnt   <= nxt_gnt;
    end
  end

`ifdef RR_ARB4_BURST_EN
  // Beat counter for the current owner's burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= nxt_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb4_p.sv
// Directed bench for rr_arb4_p: reset, single requester,
// fairness, backpressure, withdrawal, mid-beat reset, burst.
module tb_rr_arb4_p;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d3, d2, d1, d0;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic [3:0] gnt;
  logic [3:0] ack;

  int nvec;
  int nerr;

  rr_arb4_p #(.N(4), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d3        (d3),
    .d2        (d2),
    .d1        (d1),
    .d0        (d0),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .gnt       (gnt),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Advance one edge; inputs then settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    d0 = 4'h5; d1 = 4'h6; d2 = 4'hA; d3 = 4'hC;

    // Reset with all requesting
    step();
    step();
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ack",   32'(ack),       32'h0);
    chk("rst_src",   32'(out_src),   32'h0);
    chk("rst_data",  32'(out_data),  32'h5);
    rst_n = 1'b1;
    step();
    chk("first_gnt",   32'(gnt),       32'h1);
    chk("first_valid", 32'(out_valid), 32'h1);

    // Fairness: 0,1,2,3,0,1 with one ack each cycle
    for (int i = 0; i < 6; i++) begin
      chk("fair_src", 32'(out_src), 32'(i % 4));
      chk("fair_ack", 32'(ack), 32'(1 << (i % 4)));
      step();
    end

    // Single requester, back-to-back
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("one_valid", 32'(out_valid), 32'h1);
      chk("one_data",  32'(out_data),  32'hA);
      chk("one_src",   32'(out_src),   32'h2);
      chk("one_ack",   32'(ack),       32'h4);
      chk("one_gnt",   32'(gnt),       32'h4);
      step();
    end

    // Backpressure
    req = 4'b0000;
    do_reset();
    req = 4'b0011;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_gnt",   32'(gnt),       32'h1);
      chk("bp_data",  32'(out_data),  32'h5);
      chk("bp_ack",   32'(ack),       32'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ack", 32'(ack), 32'h1);
    step();
    chk("bp_next_src", 32'(out_src), 32'h1);
    chk("bp_next_gnt", 32'(gnt),     32'h2);
    chk("bp_next_dat", 32'(out_data), 32'h6);

    // Withdrawal by owner 3
    req = 4'b0000;
    do_reset();
    req = 4'b1000;
    out_ready = 1'b0;
    step();
    chk("wd_src",  32'(out_src),  32'h3);
    chk("wd_data", 32'(out_data), 32'hC);
    req = 4'b0001;
    #1;
    chk("wd_valid", 32'(out_valid), 32'h0);
    chk("wd_ack",   32'(ack),       32'h0);
    step();
    chk("wd_new_src", 32'(out_src), 32'h0);
    chk("wd_new_gnt", 32'(gnt),     32'h1);
    chk("wd_new_val", 32'(out_valid), 32'h1);

    // Reset while BUSY aborts the beat
    rst_n = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mr_gnt",   32'(gnt),       32'h0);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_ack",   32'(ack),       32'h0);
    chk("mr_src",   32'(out_src),   32'h0);
    rst_n = 1'b1;
    req = 4'b0110;
    step();
    chk("mr_restart", 32'(out_src), 32'h1);

`ifdef RR_ARB4_BURST_EN
    // Burst of MAX_BURST per owner
    req = 4'b0000;
    do_reset();
    req = 4'b0011;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("burst_src", 32'(out_src), 32'((i / 4) % 2));
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
